// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive (rx_to_mem) and transmit (MEM_to_TX) paths.
// Holds the frame format, the bit-timing helper and the receiver state encoding.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam int unsigned UART_STOP_BITS = 1;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_WRITE = 3'd4
   } rx_state_e;

   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/rx_to_mem_if.sv
// Matrix-memory write bus driven by rx_to_mem, plus its load status flags.
interface rx_to_mem_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
);
   logic              mem_we;
   logic              mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              load_done;
   logic              frame_err;

   modport master (
      output mem_we, mem_sel, mem_addr, mem_wdata, load_done, frame_err
   );

   modport slave (
      input mem_we, mem_sel, mem_addr, mem_wdata, load_done, frame_err
   );
endinterface

// File: rtl/rx_to_mem_uart_rx_core.sv
// 8N1 receive engine: two-flop synchroniser and mid-bit sampling state machine.
// Emits combinational one-cycle pulses at the confirming sample points.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_data,
   output logic                      o_byte_valid,
   output logic [UART_DATA_BITS-1:0] o_byte_data,
   output logic                      o_frame_err,
   output logic                      o_start_ok
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

   rx_state_e                 r_state;
   rx_state_e                 w_state_nxt;
   logic [1:0]                r_sync;
   logic [CNT_W-1:0]          r_cnt;
   logic [IDX_W-1:0]          r_bit_idx;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic                      w_rx_s;
   logic                      w_mid;
   logic                      w_full;

   assign w_rx_s      = r_sync[1];
   assign w_mid       = (r_cnt == CNT_W'(CLKS_PER_BIT / 2));
   assign w_full      = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign o_byte_data = r_shift;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync  <= 2'b11;
         r_state <= RX_IDLE;
      end else begin
         r_sync  <= {r_sync[0], rx_data};
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      o_byte_valid = 1'b0;
      o_frame_err  = 1'b0;
      o_start_ok   = 1'b0;
      case (r_state)
         RX_IDLE: begin
            if (!w_rx_s) w_state_nxt = RX_START;
         end
         RX_START: begin
            if (w_mid) begin
               if (w_rx_s) begin
                  w_state_nxt = RX_IDLE;
               end else begin
                  w_state_nxt = RX_DATA;
                  o_start_ok  = 1'b1;
               end
            end
         end
         RX_DATA: begin
            if (w_full && (r_bit_idx == IDX_W'(UART_DATA_BITS - 1)))
               w_state_nxt = RX_STOP;
         end
         RX_STOP: begin
            if (w_full) begin
               if (w_rx_s) begin
                  w_state_nxt  = RX_WRITE;
                  o_byte_valid = 1'b1;
               end else begin
                  w_state_nxt  = RX_IDLE;
                  o_frame_err  = 1'b1;
               end
            end
         end
         RX_WRITE: w_state_nxt = RX_IDLE;
         default:  w_state_nxt = RX_IDLE;
      endcase
   end

   // Counter restarts at the mid start bit, so each full count lands mid-bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         case (r_state)
            RX_START: r_cnt <= w_mid ? '0 : r_cnt + CNT_W'(1);
            RX_DATA: begin
               if (w_full) begin
                  r_cnt     <= '0;
                  r_bit_idx <= r_bit_idx + IDX_W'(1);
                  r_shift   <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            RX_STOP: r_cnt <= w_full ? '0 : r_cnt + CNT_W'(1);
            default: begin
               r_cnt     <= '0;
               r_bit_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/rx_to_mem.sv
// Loads matrices A then B (row-major) from UART bytes; one element per byte.
// Write strobe lands in the receiver's WRITE cycle, one clock after the stop sample.
module rx_to_mem
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600,
   parameter int unsigned N        = 3,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx_data,
   rx_to_mem_if.master  bus
);

   localparam int unsigned NN    = N * N;
   localparam int unsigned CNT_W = $clog2(2 * NN);

   logic                      w_byte_valid;
   logic [UART_DATA_BITS-1:0] w_byte_data;
   logic                      w_frame_err;
   logic                      w_start_ok;
   logic                      w_sel;
   logic [CNT_W-1:0]          w_idx;

   logic [CNT_W-1:0]  r_elem_cnt;
   logic              r_mem_we;
   logic              r_mem_sel;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_load_done;
   logic              r_frame_err;

   uart_rx_core #(
      .CLKS_PER_BIT (clks_per_bit(CLK_FREQ, BAUD))
   ) u_rx_core (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .o_byte_valid (w_byte_valid),
      .o_byte_data  (w_byte_data),
      .o_frame_err  (w_frame_err),
      .o_start_ok   (w_start_ok)
   );

   assign w_sel = (r_elem_cnt >= CNT_W'(NN));
   assign w_idx = w_sel ? (r_elem_cnt - CNT_W'(NN)) : r_elem_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_elem_cnt  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_sel   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_load_done <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_mem_we    <= w_byte_valid;
         r_frame_err <= w_frame_err;
         if (w_byte_valid) begin
            r_mem_sel   <= w_sel;
            r_mem_addr  <= ADDR_W'(w_idx);
            r_mem_wdata <= DATA_W'(w_byte_data);
            r_elem_cnt  <= (r_elem_cnt == CNT_W'(2 * NN - 1)) ? '0
                                                              : r_elem_cnt + CNT_W'(1);
         end
         // Last element is B[NN-1]; its write cycle sets load_done on the next edge.
         if (w_start_ok)
            r_load_done <= 1'b0;
         else if (r_mem_we && r_mem_sel && (r_mem_addr == ADDR_W'(NN - 1)))
            r_load_done <= 1'b1;
      end
   end

   assign bus.mem_we    = r_mem_we;
   assign bus.mem_sel   = r_mem_sel;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.load_done = r_load_done;
   assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_rx_to_mem.sv
// Directed bench for rx_to_mem at 10 clocks per bit, N=3.
module tb_rx_to_mem;

   localparam int unsigned CF  = 100;
   localparam int unsigned BD  = 10;
   localparam int unsigned NN  = 3;
   localparam int unsigned AW  = 4;
   localparam int unsigned DW  = 8;
   localparam int unsigned CPB = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rx_data = 1'b1;

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   rx_to_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   rx_to_mem #(
      .CLK_FREQ (CF),
      .BAUD     (BD),
      .N        (NN),
      .DATA_W   (DW),
      .ADDR_W   (AW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .rx_data (rx_data),
      .bus     (bus)
   );

   logic          log_sel  [128];
   logic [AW-1:0] log_addr [128];
   logic [DW-1:0] log_data [128];
   int unsigned   log_cyc  [128];
   int unsigned   wr_n = 0;
   int unsigned   fe_n = 0;
   int unsigned   ld_rise_cyc = 0;
   logic          ld_prev = 1'b0;

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1 && wr_n < 128) begin
         log_sel[wr_n]  = bus.mem_sel;
         log_addr[wr_n] = bus.mem_addr;
         log_data[wr_n] = bus.mem_wdata;
         log_cyc[wr_n]  = cyc;
         wr_n++;
      end
      if (bus.frame_err === 1'b1) fe_n++;
      if (bus.load_done === 1'b1 && ld_prev !== 1'b1) ld_rise_cyc = cyc;
      ld_prev = bus.load_done;
   end

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx_data = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_data = b[i];
         idle(CPB);
      end
      rx_data = stop_bit;
      idle(CPB);
      rx_data = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      rx_data = 1'b1;
      idle(5);
      rst = 1'b1;
      idle(5);
   endtask

   task automatic check_one_write(input string tag, input int unsigned base,
                                  input logic [7:0] exp_data);
      check({tag, "_cnt"},  wr_n - base, 32'd1);
      check({tag, "_sel"},  32'(log_sel[base]), 32'd0);
      check({tag, "_addr"}, 32'(log_addr[base]), 32'd0);
      check({tag, "_data"}, 32'(log_data[base]), 32'(exp_data));
   endtask

   int unsigned base;
   int unsigned fe_base;
   int unsigned t0;
   int unsigned lat;

   initial begin
      // Reset state
      rst = 1'b0;
      rx_data = 1'b1;
      idle(10);
      check("rst_we",    32'(bus.mem_we),    32'd0);
      check("rst_sel",   32'(bus.mem_sel),   32'd0);
      check("rst_addr",  32'(bus.mem_addr),  32'd0);
      check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
      check("rst_done",  32'(bus.load_done), 32'd0);
      check("rst_ferr",  32'(bus.frame_err), 32'd0);
      rst = 1'b1;
      base = wr_n;
      idle(200);
      check("idle_no_we", wr_n - base, 32'd0);

      // Single byte 0xA5, with latency from the start edge
      base = wr_n;
      t0 = cyc;
      send_byte(8'hA5, 1'b1);
      idle(20);
      check_one_write("a5", base, 8'hA5);
      lat = log_cyc[base] - t0;
      check("a5_latency_95_101", 32'(lat >= 95 && lat <= 101), 32'd1);

      // Full load 1..18
      do_reset();
      base = wr_n;
      for (int i = 0; i < 18; i++) send_byte(8'(i + 1), 1'b1);
      idle(5);
      check("load_cnt", wr_n - base, 32'd18);
      for (int i = 0; i < 18; i++) begin
         check($sformatf("load_sel%0d", i),  32'(log_sel[base + i]),  32'(i >= 9));
         check($sformatf("load_addr%0d", i), 32'(log_addr[base + i]), 32'(i % 9));
         check($sformatf("load_data%0d", i), 32'(log_data[base + i]), 32'(i + 1));
      end
      check("done_rise", ld_rise_cyc - log_cyc[base + 17], 32'd1);
      idle(50);
      check("done_hold", 32'(bus.load_done), 32'd1);
      base = wr_n;
      send_byte(8'h33, 1'b1);
      idle(20);
      check_one_write("reload", base, 8'h33);
      check("reload_done_clr", 32'(bus.load_done), 32'd0);

      // Glitch shorter than half a bit
      do_reset();
      base = wr_n;
      fe_base = fe_n;
      rx_data = 1'b0;
      idle(3);
      rx_data = 1'b1;
      idle(30);
      check("glitch_no_we",   wr_n - base, 32'd0);
      check("glitch_no_ferr", fe_n - fe_base, 32'd0);
      send_byte(8'h42, 1'b1);
      idle(20);
      check_one_write("post_glitch", base, 8'h42);

      // Framing error: bad stop bit
      do_reset();
      base = wr_n;
      fe_base = fe_n;
      send_byte(8'h7E, 1'b0);
      idle(30);
      check("ferr_cycles", fe_n - fe_base, 32'd1);
      check("ferr_no_we",  wr_n - base, 32'd0);
      send_byte(8'h11, 1'b1);
      idle(20);
      check_one_write("post_ferr", base, 8'h11);

      // Reset in the middle of byte 6
      do_reset();
      base = wr_n;
      for (int i = 0; i < 5; i++) send_byte(8'(8'h51 + i), 1'b1);
      idle(5);
      check("mid_pre_cnt", wr_n - base, 32'd5);
      check("mid_pre_addr4", 32'(log_addr[base + 4]), 32'd4);
      rx_data = 1'b0;
      idle(CPB);
      rx_data = 1'b1;
      idle(4 * CPB);
      rst = 1'b0;
      idle(3);
      rx_data = 1'b1;
      rst = 1'b1;
      idle(120);
      check("mid_no_write", wr_n - base, 32'd5);
      base = wr_n;
      send_byte(8'h99, 1'b1);
      idle(20);
      check_one_write("post_mid_rst", base, 8'h99);
      check("post_mid_done", 32'(bus.load_done), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rx_to_mem.md
Name: rx_to_mem

Overview:
- UART receive front end that loads both operand matrices for the matrix multiplier.
- Deserialises 8N1 bytes from the host serial line.
- Writes each byte as one element: the first N*N bytes go into matrix A memory and the next N*N into matrix B memory, both row-major.
- Asserts load_done when both are complete. It sits upstream of the multiplier, mirroring MEM_to_TX on the output side.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- N, 3, matrix dimension (N x N elements per matrix).
- DATA_W, 8, element width in bits (one UART byte per element).
- ADDR_W, 4, memory address width; must satisfy 2^ADDR_W >= N*N.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rx_data  input  1  serial line from host, idle high, asynchronous to clk.
- mem_we  output  1  one-cycle write strobe.
- mem_sel  output  1  target memory: 0 = A, 1 = B.
- mem_addr  output  ADDR_W  element index within the selected matrix, row*N+col.
- mem_wdata  output  DATA_W  received byte.
- load_done  output  1  high once all 2*N*N elements are written.
- frame_err  output  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset: asynchronous and active-low. When rst=0, all outputs are 0, the FSM goes to IDLE, the element counter is 0, and both synchroniser flops are set to 1 (idle line). Reset asserted mid-byte or mid-load aborts the load immediately; nothing further is written.
- Synchroniser: rx_data passes through 2 flops. All sampling uses the synchronised rx_s.
- Bit timing: CLKS_PER_BIT = CLK_FREQ/BAUD (integer division). A bit counter counts 0..CLKS_PER_BIT-1.
- FSM states are IDLE, START, DATA, STOP, WRITE.
- IDLE: wait for rx_s=0, then go to START with the bit counter cleared.
- START: at count CLKS_PER_BIT/2 (mid start bit), re-sample rx_s.
  - rx_s=1: false start; return to IDLE with no side effects.
  - rx_s=0: clear the counter and go to DATA.
- DATA: sample every CLKS_PER_BIT clocks (mid-bit), LSB first, into a shift register. After bit 7, go to STOP.
- STOP: sample at mid stop bit.
  - rx_s=1: go to WRITE.
  - rx_s=0: pulse frame_err for 1 cycle, discard the byte, do not advance the counter, and go to IDLE. Do not wait for the line to go high; IDLE re-arms on the next falling edge.
- WRITE: exactly one cycle with mem_we=1.
  - mem_wdata = byte.
  - mem_sel = (elem_cnt >= N*N).
  - mem_addr = elem_cnt mod N*N, computed by subtracting N*N when sel=1 (no divider).
  - Then elem_cnt increments and the FSM returns to IDLE.
- Completion: on the write of element 2*N*N-1, load_done goes to 1 on the following cycle and elem_cnt wraps to 0. load_done holds 1.
- New load: while load_done=1, a valid start bit (confirmed at mid start) clears load_done and begins a new load at A[0].
- Output timing: mem_sel, mem_addr and mem_wdata are valid only while mem_we=1. Outside WRITE they hold their last values.
- Latency: mem_we asserts 1 clock after the stop-bit mid-sample, about 9.5 bit times after the start edge.
- Simultaneous events: none are possible. The FSM handles exactly one byte at a time, and any start edge during WRITE is caught in IDLE on the next cycle, since the stop bit is still high.

Decomposition:
- Shared package uart_pkg:
  - Function clks_per_bit(CLK_FREQ, BAUD).
  - Localparams for the FSM state encodings.
  - UART frame constants: 8 data bits, 1 stop bit.
  - The MEM_to_TX transmitter imports the same package.
- Sub-module uart_rx_core: synchroniser plus the START/DATA/STOP bit engine.
  - Outputs: byte_valid (1-cycle), byte_data, frame_err.
  - rx_to_mem adds the element counter, A/B addressing, the WRITE strobe and load_done.

Test Plan (sim override: CLK_FREQ=100, BAUD=10, giving 10 clocks/bit; N=3):
- Reset: hold rst=0 with rx_data=1 for 10 cycles -> all outputs 0. Release rst -> no mem_we while the line idles for 200 cycles.
- Single byte 0xA5 (8N1, LSB first) -> exactly one mem_we pulse with sel=0, addr=0, wdata=0xA5, about 96 clocks after the start edge.
- Full load of bytes 1..18 -> writes to A[0..8]=1..9 and B[0..8]=10..18.
  - load_done rises one cycle after the 18th mem_we and stays high.
  - Next valid byte 0x33 clears load_done and writes A[0]=0x33.
- Glitch: rx low for 3 clocks then high -> no write, no frame_err, FSM back in IDLE. Next byte 0x42 -> written to A[0].
- Framing error: send 0x7E with stop bit 0 -> frame_err single pulse, no mem_we. Next good byte 0x11 -> written to A[0], showing the counter did not advance.
- Reset mid-load: after 5 bytes, pulse rst=0 mid-way through byte 6 -> no write for byte 6. Next byte 0x99 -> written to A[0]; load_done stays 0.
